// File: rtl/sim_pkg.sv
// Shared constants and state type for the simulation run monitor.
// Purely declarative: no latency, no flow control.
package sim_pkg;

    localparam logic [1:0] DC_NONE  = 2'd0;
    localparam logic [1:0] DC_END   = 2'd1;
    localparam logic [1:0] DC_LIMIT = 2'd2;
    localparam logic [1:0] DC_WDOG  = 2'd3;

    localparam logic [31:0] SDBBP_INST = 32'h7000_003f;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over enable.
// Latency: count visible one cycle after enable; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sim_run_monitor.sv
// Sequences DUT reset, counts RUN cycles/retires, detects end-of-test and traces retires.
// Latency: all outputs registered, one cycle after the causing input; no backpressure.
module sim_run_monitor
    import sim_pkg::*;
#(
    parameter int                 ADDR_W       = 32,
    parameter int                 INST_W       = 32,
    parameter int                 CNT_W        = 32,
    parameter int                 RESET_CYCLES = 10,
    parameter int                 SIM_CYCLE    = 100,
    parameter logic [INST_W-1:0]  END_INST     = INST_W'(SDBBP_INST),
    parameter int                 WATCHDOG     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    output logic              dut_rst_n,
    output logic              running,
    output logic              done,
    output logic [1:0]        done_code,
    output logic [CNT_W-1:0]  cycles,
    output logic [CNT_W-1:0]  retired,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [INST_W-1:0] trace_inst
);

    // Terminal values are compared against pre-increment counts.
    localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LIM_LAST  = CNT_W'(SIM_CYCLE - 1);
    localparam logic [CNT_W-1:0] LP_WDOG_LAST = CNT_W'(WATCHDOG - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_done_code;
    logic [1:0]        w_code_nxt;
    logic              r_trace_vld;
    logic [ADDR_W-1:0] r_trace_pc;
    logic [INST_W-1:0] r_trace_inst;

    logic              w_in_hold;
    logic              w_in_run;
    logic              w_retire;
    logic              w_fire_end;
    logic              w_fire_wdog;
    logic              w_fire_lim;
    logic [CNT_W-1:0]  w_hold_cnt;
    logic [CNT_W-1:0]  w_wdog_cnt;
    logic [CNT_W-1:0]  w_cyc_cnt;
    logic [CNT_W-1:0]  w_ret_cnt;

    assign w_in_hold   = (r_state == ST_HOLD);
    assign w_in_run    = (r_state == ST_RUN);
    assign w_retire    = w_in_run && inst_valid;
    assign w_fire_end  = w_retire && (inst == END_INST);
    assign w_fire_wdog = (WATCHDOG != 0) && w_in_run && !inst_valid && (w_wdog_cnt == LP_WDOG_LAST);
    assign w_fire_lim  = (SIM_CYCLE != 0) && w_in_run && (w_cyc_cnt == LP_LIM_LAST);

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_in_hold),
        .o_cnt (w_hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wdog_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_retire),
        .i_en  (w_in_run && !inst_valid),
        .o_cnt (w_wdog_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_in_run),
        .o_cnt (w_cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_retire),
        .o_cnt (w_ret_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_done_code;
        case (r_state)
            ST_HOLD: begin
                if (w_hold_cnt == LP_HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire_end) begin
                    w_state_nxt = ST_DONE;
                    w_code_nxt  = DC_END;
                end else if (w_fire_wdog) begin
                    w_state_nxt = ST_DONE;
                    w_code_nxt  = DC_WDOG;
                end else if (w_fire_lim) begin
                    w_state_nxt = ST_DONE;
                    w_code_nxt  = DC_LIMIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_done_code <= DC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_done_code <= w_code_nxt;
        end
    end

    // Trace payload holds its last value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trace_vld  <= 1'b0;
            r_trace_pc   <= '0;
            r_trace_inst <= '0;
        end else begin
            r_trace_vld <= w_retire;
            if (w_retire) begin
                r_trace_pc   <= pc;
                r_trace_inst <= inst;
            end
        end
    end

    assign dut_rst_n   = !w_in_hold;
    assign running     = w_in_run;
    assign done        = (r_state == ST_DONE);
    assign done_code   = r_done_code;
    assign cycles      = w_cyc_cnt;
    assign retired     = w_ret_cnt;
    assign trace_valid = r_trace_vld;
    assign trace_pc    = r_trace_pc;
    assign trace_inst  = r_trace_inst;

endmodule

// File: doc/sim_run_monitor.md
Name: sim_run_monitor

Overview:
Synthesizable run controller and monitor placed beside the Top instance in simulation tops and FPGA bring-up shells. It sequences the DUT reset, counts cycles and retired instructions, and detects end-of-test conditions: the sdbbp end instruction, a cycle limit, or a PC-stall watchdog. It latches a completion code and exposes a one-cycle trace strobe per retired instruction, so harnesses and on-board logic share one termination mechanism.

Parameters:
ADDR_W, 32, PC width
INST_W, 32, instruction width
CNT_W, 32, width of the cycle and retire counters
RESET_CYCLES, 10, cycles dut_rst_n is held low after rst deasserts (>=1)
SIM_CYCLE, 100, cycle limit in RUN; 0 disables the limit
END_INST, 32'h7000_003f, instruction encoding that ends the test
WATCHDOG, 64, consecutive RUN cycles without a retire before timeout; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
inst_valid  in  1  DUT retires inst at pc this cycle
pc  in  ADDR_W  PC of the retiring instruction
inst  in  INST_W  retiring instruction word
dut_rst_n  out  1  active-low reset driven to the DUT
running  out  1  state == RUN
done  out  1  sticky; a termination condition has fired
done_code  out  2  0 none, 1 end instruction, 2 cycle limit, 3 watchdog
cycles  out  CNT_W  RUN cycles elapsed
retired  out  CNT_W  instructions retired in RUN
trace_valid  out  1  one-cycle strobe mirroring a retire in RUN
trace_pc  out  ADDR_W  registered pc for the trace
trace_inst  out  INST_W  registered inst for the trace

Behaviour:
- Reset values (rst=1 at the clock edge): state HOLD; dut_rst_n=0, running=0, done=0, done_code=0, cycles=0, retired=0, trace_valid=0, trace_pc=0, trace_inst=0; hold and watchdog counters cleared.
- States: HOLD -> RUN -> DONE. DONE exits only through rst.
- HOLD: the hold counter increments each cycle. After RESET_CYCLES cycles with rst=0, the state moves to RUN and dut_rst_n registers 1 on that same edge. inst_valid is ignored in HOLD.
- RUN: cycles increments each cycle and saturates at all-ones. When inst_valid=1, retired increments and saturates, trace_valid=1 on the next cycle with trace_pc/trace_inst registered, and the watchdog counter clears. When inst_valid=0, the watchdog counter increments.
- Termination is evaluated on each RUN cycle using the pre-increment counters. Priority when several conditions are true in the same cycle:
  - end: inst_valid && inst==END_INST -> code 1. The end instruction is counted in retired and traced.
  - watchdog: WATCHDOG!=0 && the watchdog counter reaches WATCHDOG-1 with inst_valid=0 -> code 3.
  - limit: SIM_CYCLE!=0 && cycles reaches SIM_CYCLE-1 -> code 2.
- A firing condition moves the state to DONE on the next edge, where done=1 and done_code are set, running=0, and the counters freeze at their final values. cycles then equals the number of RUN cycles including the firing cycle.
- DONE: dut_rst_n stays 1. No further traces; all inputs are ignored.
- rst asserted in any state returns everything to the reset values on the next edge, including mid-run and in DONE.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package sim_pkg: done_code constants (DC_NONE, DC_END, DC_LIMIT, DC_WDOG), state typedef, SDBBP_INST constant.
- One natural sub-module, sat_counter (parametrised width; clear, enable, saturate), instantiated for cycles, retired, the hold counter and the watchdog counter.

Test Plan:
- Reset sequence (RESET_CYCLES=10): rst high for 2 cycles, then low -> dut_rst_n low for exactly 10 cycles, then high together with running=1; cycles=0 at entry.
- End instruction: retire 5 NOPs, then 32'h7000_003f -> done=1, done_code=1, retired=6, 6 trace strobes with matching pc/inst, counters frozen thereafter.
- Cycle limit (SIM_CYCLE=100, no end instruction, retire every cycle) -> done_code=2, cycles=100, retired=100.
- Watchdog (WATCHDOG=8): retire 3 instructions, then inst_valid=0 -> done_code=3 after 8 idle cycles; a retire on idle cycle 7 clears the counter and prevents timeout.
- Simultaneous conditions: end instruction on the cycle-limit cycle -> done_code=1. Watchdog expiry on the cycle-limit cycle -> done_code=3.
- rst mid-RUN and in DONE -> all outputs return to reset values on the next edge, and the HOLD sequence repeats exactly.
